clock_monitor: RTL and testbench

Checks the divided pixel clock produced by the PLL block before the display timing logic may rely on it. It runs on a fast reference clock and samples the monitored clock as data through a synchronizer. For every period it measures the length and high time, checks both against fixed windows, and asserts `clk_ok` only after a run of consecutive good periods while the PLL reports lock. Downstream blocks gate their reset release on `clk_ok`; `err_sticky` is visible to debug logic.

---
 rtl/clock_monitor.sv | 159 +++++++++++++++
 tb/tb_clock_monitor.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_monitor.sv
// Qualifies an asynchronous monitored clock by measuring its period and high time
// on a fast reference clock, and raising clk_ok after a run of good periods under PLL lock.
module clock_monitor #(
    parameter int unsigned CW         = 8,
    parameter int unsigned PERIOD_MIN = 8,
    parameter int unsigned PERIOD_MAX = 10,
    parameter int unsigned HIGH_MIN   = 3,
    parameter int unsigned HIGH_MAX   = 5,
    parameter int unsigned GOOD_COUNT = 16
) (
    input  logic          clock_in,
    input  logic          reset,
    input  logic          mon_in,
    input  logic          locked_in,
    input  logic          clear_err,
    output logic          clk_ok,
    output logic          err_sticky,
    output logic          meas_valid,
    output logic [CW-1:0] period_out,
    output logic [CW-1:0] high_out
);

    localparam int unsigned    GW        = $clog2(GOOD_COUNT + 1);
    localparam logic [CW-1:0]  CNT_MAX   = {CW{1'b1}};
    localparam logic [CW-1:0]  PER_MIN_C = CW'(PERIOD_MIN);
    localparam logic [CW-1:0]  PER_MAX_C = CW'(PERIOD_MAX);
    localparam logic [CW-1:0]  HI_MIN_C  = CW'(HIGH_MIN);
    localparam logic [CW-1:0]  HI_MAX_C  = CW'(HIGH_MAX);
    localparam logic [GW-1:0]  GOOD_C    = GW'(GOOD_COUNT);

    logic          s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic          lk1_q, lk1_d, lock_s_q, lock_s_d;
    logic [CW-1:0] per_cnt_q, per_cnt_d, high_cnt_q, high_cnt_d;
    logic [CW-1:0] period_out_q, period_out_d, high_out_q, high_out_d;
    logic          primed_q, primed_d, meas_valid_q, meas_valid_d;
    logic          err_sticky_q, err_sticky_d, clk_ok_q, clk_ok_d;
    logic [GW-1:0] good_run_q, good_run_d;

    logic rise_s, period_good_s, timeout_s, eval_s, err_event_s;

    // Next-state logic: synchronizers, counters, evaluation and qualification.
    always_comb begin
        s1_d     = mon_in;
        s2_d     = s1_q;
        s3_d     = s2_q;
        lk1_d    = locked_in;
        lock_s_d = lk1_q;

        rise_s        = s2_q & ~s3_q;
        period_good_s = (per_cnt_q >= PER_MIN_C) && (per_cnt_q <= PER_MAX_C) &&
                        (high_cnt_q >= HI_MIN_C) && (high_cnt_q <= HI_MAX_C);
        // A stall is reported only while primed, so a stuck input times out once.
        timeout_s     = ~rise_s & primed_q & (per_cnt_q == PER_MAX_C);
        eval_s        = rise_s & primed_q;
        err_event_s   = timeout_s | (eval_s & ~period_good_s);

        if (rise_s) begin
            per_cnt_d = CW'(1);
        end else if (per_cnt_q != CNT_MAX) begin
            per_cnt_d = per_cnt_q + CW'(1);
        end else begin
            per_cnt_d = per_cnt_q;
        end

        if (rise_s) begin
            high_cnt_d = CW'(1);
        end else if (s2_q && (high_cnt_q != CNT_MAX)) begin
            high_cnt_d = high_cnt_q + CW'(1);
        end else begin
            high_cnt_d = high_cnt_q;
        end

        if (rise_s) begin
            period_out_d = per_cnt_q;
            high_out_d   = high_cnt_q;
        end else begin
            period_out_d = period_out_q;
            high_out_d   = high_out_q;
        end
        meas_valid_d = eval_s;

        if (!lock_s_q) begin
            primed_d = 1'b0;
        end else if (rise_s) begin
            primed_d = 1'b1;
        end else if (timeout_s) begin
            primed_d = 1'b0;
        end else begin
            primed_d = primed_q;
        end

        if (!lock_s_q || timeout_s) begin
            good_run_d = '0;
        end else if (eval_s) begin
            if (!period_good_s) begin
                good_run_d = '0;
            end else if (good_run_q != GOOD_C) begin
                good_run_d = good_run_q + GW'(1);
            end else begin
                good_run_d = good_run_q;
            end
        end else begin
            good_run_d = good_run_q;
        end

        // An error event in the same cycle as a clear request keeps the flag set.
        if (err_event_s) begin
            err_sticky_d = 1'b1;
        end else if (clear_err) begin
            err_sticky_d = 1'b0;
        end else begin
            err_sticky_d = err_sticky_q;
        end

        clk_ok_d = lock_s_q & (good_run_d == GOOD_C);
    end

    // State register with synchronous reset.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            s3_q         <= 1'b0;
            lk1_q        <= 1'b0;
            lock_s_q     <= 1'b0;
            per_cnt_q    <= '0;
            high_cnt_q   <= '0;
            period_out_q <= '0;
            high_out_q   <= '0;
            primed_q     <= 1'b0;
            meas_valid_q <= 1'b0;
            good_run_q   <= '0;
            err_sticky_q <= 1'b0;
            clk_ok_q     <= 1'b0;
        end else begin
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            s3_q         <= s3_d;
            lk1_q        <= lk1_d;
            lock_s_q     <= lock_s_d;
            per_cnt_q    <= per_cnt_d;
            high_cnt_q   <= high_cnt_d;
            period_out_q <= period_out_d;
            high_out_q   <= high_out_d;
            primed_q     <= primed_d;
            meas_valid_q <= meas_valid_d;
            good_run_q   <= good_run_d;
            err_sticky_q <= err_sticky_d;
            clk_ok_q     <= clk_ok_d;
        end
    end

    assign clk_ok     = clk_ok_q;
    assign err_sticky = err_sticky_q;
    assign meas_valid = meas_valid_q;
    assign period_out = period_out_q;
    assign high_out   = high_out_q;

endmodule

// File: tb/tb_clock_monitor.sv
// Directed self-checking bench for clock_monitor: qualification, timeouts, bad periods,
// lock loss, stuck input, clear/error collision and mid-period reset.
module tb_clock_monitor;

    logic       clock_in;
    logic       reset;
    logic       mon_in;
    logic       locked_in;
    logic       clear_err;
    logic       clk_ok;
    logic       err_sticky;
    logic       meas_valid;
    logic [7:0] period_out;
    logic [7:0] high_out;

    int checks = 0;
    int errors = 0;
    int mv_cnt = 0;
    int mv_base;

    clock_monitor dut (
        .clock_in   (clock_in),
        .reset      (reset),
        .mon_in     (mon_in),
        .locked_in  (locked_in),
        .clear_err  (clear_err),
        .clk_ok     (clk_ok),
        .err_sticky (err_sticky),
        .meas_valid (meas_valid),
        .period_out (period_out),
        .high_out   (high_out)
    );

    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    // Count measurement pulses away from the active edge.
    always @(negedge clock_in) begin
        if (meas_valid === 1'b1) mv_cnt <= mv_cnt + 1;
    end

    task automatic step();
        @(posedge clock_in);
        #1;
    endtask

    // One monitored period: hi cycles high, lo cycles low; clear_err pulsed at step clr_at.
    task automatic mon_period(input int hi, input int lo, input int clr_at);
        for (int k = 0; k < hi + lo; k++) begin
            mon_in    = (k < hi);
            clear_err = (k == clr_at);
            step();
        end
        clear_err = 1'b0;
    endtask

    task automatic run_good(input int n);
        for (int i = 0; i < n; i++) mon_period(4, 5, -1);
    endtask

    task automatic test_reset();
        reset = 1'b1; mon_in = 1'b0; locked_in = 1'b0; clear_err = 1'b0;
        step(); step();
        checks++;
        if ({clk_ok, err_sticky, meas_valid, period_out, high_out} !== 19'd0) begin
            errors++;
            $display("FAIL reset_outputs: got ok=%b err=%b mv=%b per=%0d hi=%0d, expected all 0",
                     clk_ok, err_sticky, meas_valid, period_out, high_out);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_qualification();
        locked_in = 1'b1;
        step(); step(); step();
        mv_base = mv_cnt;
        run_good(16);
        checks++;
        if (clk_ok !== 1'b0) begin
            errors++; $display("FAIL qual_early_ok: got %b expected 0", clk_ok);
        end
        run_good(1);
        checks++;
        if (clk_ok !== 1'b1) begin
            errors++; $display("FAIL qual_ok: got %b expected 1", clk_ok);
        end
        checks++;
        if (period_out !== 8'd9 || high_out !== 8'd4) begin
            errors++; $display("FAIL qual_meas: got per=%0d hi=%0d expected 9/4", period_out, high_out);
        end
        checks++;
        if (mv_cnt - mv_base !== 16) begin
            errors++; $display("FAIL qual_mv_count: got %0d expected 16", mv_cnt - mv_base);
        end
        checks++;
        if (err_sticky !== 1'b0) begin
            errors++; $display("FAIL qual_err: got %b expected 0", err_sticky);
        end
    endtask

    task automatic test_stretch();
        mon_period(4, 10, -1);
        checks++;
        if (clk_ok !== 1'b0 || err_sticky !== 1'b1) begin
            errors++; $display("FAIL stretch_timeout: got ok=%b err=%b expected 0/1", clk_ok, err_sticky);
        end
        mv_base = mv_cnt;
        mon_period(4, 5, -1);
        checks++;
        if (mv_cnt - mv_base !== 0 || period_out !== 8'd14) begin
            errors++; $display("FAIL stretch_prime: got mv=%0d per=%0d expected 0/14", mv_cnt - mv_base, period_out);
        end
        run_good(15);
        checks++;
        if (clk_ok !== 1'b0) begin
            errors++; $display("FAIL stretch_early_ok: got %b expected 0", clk_ok);
        end
        run_good(1);
        checks++;
        if (clk_ok !== 1'b1 || err_sticky !== 1'b1) begin
            errors++; $display("FAIL stretch_requal: got ok=%b err=%b expected 1/1", clk_ok, err_sticky);
        end
    endtask

    task automatic test_clear_and_bad();
        mon_period(4, 5, 5);
        checks++;
        if (err_sticky !== 1'b0 || clk_ok !== 1'b1) begin
            errors++; $display("FAIL clear_alone: got err=%b ok=%b expected 0/1", err_sticky, clk_ok);
        end
        mon_period(3, 3, -1);
        mon_period(4, 5, 2);
        checks++;
        if (err_sticky !== 1'b1 || clk_ok !== 1'b0) begin
            errors++; $display("FAIL clear_collision: got err=%b ok=%b expected 1/0", err_sticky, clk_ok);
        end
        checks++;
        if (period_out !== 8'd6 || high_out !== 8'd3) begin
            errors++; $display("FAIL bad_length_meas: got per=%0d hi=%0d expected 6/3", period_out, high_out);
        end
        mon_period(7, 2, 5);
        checks++;
        if (err_sticky !== 1'b0) begin
            errors++; $display("FAIL clear_before_duty: got %b expected 0", err_sticky);
        end
        mon_period(4, 5, -1);
        checks++;
        if (err_sticky !== 1'b1 || period_out !== 8'd9 || high_out !== 8'd7) begin
            errors++; $display("FAIL bad_duty: got err=%b per=%0d hi=%0d expected 1/9/7", err_sticky, period_out, high_out);
        end
    endtask

    task automatic test_boundaries();
        mon_period(4, 5, 5);
        mon_period(3, 5, -1);
        mon_period(5, 5, -1);
        checks++;
        if (err_sticky !== 1'b0 || period_out !== 8'd8 || high_out !== 8'd3) begin
            errors++; $display("FAIL bound_min: got err=%b per=%0d hi=%0d expected 0/8/3", err_sticky, period_out, high_out);
        end
        mon_period(4, 5, -1);
        checks++;
        if (err_sticky !== 1'b0 || period_out !== 8'd10 || high_out !== 8'd5) begin
            errors++; $display("FAIL bound_max: got err=%b per=%0d hi=%0d expected 0/10/5", err_sticky, period_out, high_out);
        end
        mon_period(4, 7, -1);
        checks++;
        if (err_sticky !== 1'b0) begin
            errors++; $display("FAIL bound_early_timeout: got %b expected 0", err_sticky);
        end
        mv_base = mv_cnt;
        mon_period(4, 5, -1);
        checks++;
        if (err_sticky !== 1'b1 || period_out !== 8'd11 || mv_cnt - mv_base !== 0) begin
            errors++; $display("FAIL bound_over_max: got err=%b per=%0d mv=%0d expected 1/11/0",
                               err_sticky, period_out, mv_cnt - mv_base);
        end
    endtask

    task automatic test_lock_loss();
        mon_period(4, 5, 5);
        run_good(15);
        checks++;
        if (clk_ok !== 1'b1 || err_sticky !== 1'b0) begin
            errors++; $display("FAIL lock_pre: got ok=%b err=%b expected 1/0", clk_ok, err_sticky);
        end
        locked_in = 1'b0;
        mon_in    = 1'b1;
        step(); step();
        checks++;
        if (clk_ok !== 1'b1) begin
            errors++; $display("FAIL lock_sync_delay: got %b expected 1", clk_ok);
        end
        step();
        checks++;
        if (clk_ok !== 1'b0 || err_sticky !== 1'b0) begin
            errors++; $display("FAIL lock_drop: got ok=%b err=%b expected 0/0", clk_ok, err_sticky);
        end
        step();
        mon_in = 1'b0;
        for (int i = 0; i < 5; i++) step();
        mv_base = mv_cnt;
        run_good(3);
        checks++;
        if (mv_cnt - mv_base !== 0 || clk_ok !== 1'b0 || err_sticky !== 1'b0) begin
            errors++; $display("FAIL lock_unlocked: got mv=%0d ok=%b err=%b expected 0/0/0",
                               mv_cnt - mv_base, clk_ok, err_sticky);
        end
    endtask

    task automatic test_stuck();
        locked_in = 1'b1;
        run_good(3);
        mon_in = 1'b1;
        for (int i = 0; i < 15; i++) step();
        checks++;
        if (err_sticky !== 1'b1) begin
            errors++; $display("FAIL stuck_timeout: got %b expected 1", err_sticky);
        end
        mv_base   = mv_cnt;
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        for (int i = 0; i < 30; i++) step();
        checks++;
        if (err_sticky !== 1'b0 || mv_cnt - mv_base !== 0 || period_out !== 8'd9 || clk_ok !== 1'b0) begin
            errors++; $display("FAIL stuck_idle: got err=%b mv=%0d per=%0d ok=%b expected 0/0/9/0",
                               err_sticky, mv_cnt - mv_base, period_out, clk_ok);
        end
    endtask

    task automatic test_reset_mid();
        mon_period(4, 5, -1);
        mon_period(3, 3, -1);
        mon_period(4, 5, -1);
        checks++;
        if (err_sticky !== 1'b1 || period_out !== 8'd6) begin
            errors++; $display("FAIL pre_reset_state: got err=%b per=%0d expected 1/6", err_sticky, period_out);
        end
        mon_in = 1'b1;
        for (int i = 0; i < 4; i++) step();
        reset  = 1'b1;
        mon_in = 1'b0;
        step();
        checks++;
        if ({clk_ok, err_sticky, meas_valid, period_out, high_out} !== 19'd0) begin
            errors++;
            $display("FAIL reset_mid: got ok=%b err=%b mv=%b per=%0d hi=%0d, expected all 0",
                     clk_ok, err_sticky, meas_valid, period_out, high_out);
        end
        reset   = 1'b0;
        mv_base = mv_cnt;
        mon_period(4, 5, -1);
        checks++;
        if (mv_cnt - mv_base !== 0) begin
            errors++; $display("FAIL reset_prime: got mv=%0d expected 0", mv_cnt - mv_base);
        end
        mon_period(4, 5, -1);
        checks++;
        if (mv_cnt - mv_base !== 1 || period_out !== 8'd9 || err_sticky !== 1'b0) begin
            errors++; $display("FAIL reset_first_meas: got mv=%0d per=%0d err=%b expected 1/9/0",
                               mv_cnt - mv_base, period_out, err_sticky);
        end
    endtask

    initial begin
        test_reset();
        test_qualification();
        test_stretch();
        test_clear_and_bad();
        test_boundaries();
        test_lock_loss();
        test_stuck();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
